// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: request/response bundle between two requesters and the
// shared-ALU arbiter. Index n of every 2-wide field belongs to requester n.
//   req_valid_i/req_ready_o      : per-requester request handshake
//   req_a_i/req_b_i              : per-requester operands (XLEN each)
//   req_alu_control_i/funct3_i   : per-requester ALU control (5) and funct3 (3)
//   rsp_valid_o/rsp_ready_i      : per-requester response handshake
//   rsp_result_o/rsp_zero_o      : shared registered result, qualified by rsp_valid_o
// master = requester side, slave = arbiter side.
interface alu_arbiter_if #(
  parameter int unsigned XLEN = 32
);
  logic [1:0]           req_valid_i;
  logic [1:0]           req_ready_o;
  logic [1:0][XLEN-1:0] req_a_i;
  logic [1:0][XLEN-1:0] req_b_i;
  logic [1:0][4:0]      req_alu_control_i;
  logic [1:0][2:0]      req_funct3_i;
  logic [1:0]           rsp_valid_o;
  logic [1:0]           rsp_ready_i;
  logic [XLEN-1:0]      rsp_result_o;
  logic                 rsp_zero_o;

  modport master (
    output req_valid_i, req_a_i, req_b_i, req_alu_control_i, req_funct3_i,
           rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_result_o, rsp_zero_o
  );

  modport slave (
    input  req_valid_i, req_a_i, req_b_i, req_alu_control_i, req_funct3_i,
           rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_result_o, rsp_zero_o
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter/sequencer sharing one combinational ALU
// between two requesters. Granted operands are registered and drive the ALU;
// the ALU result is captured one cycle later and held until the owner accepts.
// Ports:
//   clk_i, rst_ni       : clock, asynchronous active-low reset
//   bus (slave)         : request/response channels (see alu_arbiter_if)
//   alu_a_o/alu_b_o     : ALU operands (from operand registers)
//   alu_control_o/alu_funct3_o : ALU control/funct3 (from operand registers)
//   alu_result_i/alu_zero_i    : combinational ALU result and zero flag
//   busy_o              : high while an operation is in EXEC or RESP
module alu_arbiter #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  alu_arbiter_if.slave    bus,
  output logic [XLEN-1:0] alu_a_o,
  output logic [XLEN-1:0] alu_b_o,
  output logic [4:0]      alu_control_o,
  output logic [2:0]      alu_funct3_o,
  input  logic [XLEN-1:0] alu_result_i,
  input  logic            alu_zero_i,
  output logic            busy_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic            last_grant_q;
  logic            grant_q;
  logic [XLEN-1:0] a_q, b_q;
  logic [4:0]      ctl_q;
  logic [2:0]      f3_q;
  logic [XLEN-1:0] result_q;
  logic            zero_q;

  logic            win;
  logic            any_valid;
  logic            owner_ready;
  logic            accept;

  // Round-robin: a lone requester wins; on contention the one that was not
  // granted last wins.
  always_comb begin
    win = 1'b0;
    case (bus.req_valid_i)
      2'b10:   win = 1'b1;
      2'b11:   win = ~last_grant_q;
      default: win = 1'b0;
    endcase
  end

  assign any_valid   = |bus.req_valid_i;
  assign owner_ready = bus.rsp_ready_i[grant_q];

  // A new request may be taken in IDLE, or in RESP on the same edge the owner
  // consumes its result (combinational rsp_ready_i -> req_ready_o path).
  assign accept = any_valid &
                  ((state_q == IDLE) || ((state_q == RESP) && owner_ready));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (owner_ready) state_d = accept ? EXEC : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      ctl_q        <= '0;
      f3_q         <= '0;
      result_q     <= '0;
      zero_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        grant_q      <= win;
        last_grant_q <= win;
        a_q          <= bus.req_a_i[win];
        b_q          <= bus.req_b_i[win];
        ctl_q        <= bus.req_alu_control_i[win];
        f3_q         <= bus.req_funct3_i[win];
      end
      if (state_q == EXEC) begin
        result_q <= alu_result_i;
        zero_q   <= alu_zero_i;
      end
    end
  end

  assign bus.req_ready_o  = accept ? (win ? 2'b10 : 2'b01) : 2'b00;
  assign bus.rsp_valid_o  = (state_q == RESP) ? (grant_q ? 2'b10 : 2'b01) : 2'b00;
  assign bus.rsp_result_o = result_q;
  assign bus.rsp_zero_o   = zero_q;

  assign alu_a_o       = a_q;
  assign alu_b_o       = b_q;
  assign alu_control_o = ctl_q;
  assign alu_funct3_o  = f3_q;
  assign busy_o        = (state_q != IDLE);

endmodule
